// File: rtl/any1_vmem_seq_pkg.sv
// any1_vmem_seq_pkg: sequencer state type, element count and vector memory opcode decode
package any1_vmem_seq_pkg;

    localparam int NEL = 64;

    typedef enum logic [2:0] {IDLE, STEP, EAW, REQ, DONE} vmseq_state_t;

    localparam logic [6:0] OP_LDSX   = 7'h50;
    localparam logic [6:0] OP_STSX   = 7'h51;
    localparam logic [6:0] OP_LDXVX  = 7'h52;
    localparam logic [6:0] OP_STXVX  = 7'h53;
    localparam logic [6:0] OP_CVLDSX = 7'h54;
    localparam logic [6:0] OP_CVSTSX = 7'h55;

    // Lets issue gate start to the strided, indexed and compressed vector memory ops
    function automatic logic is_vmem(input logic [6:0] opcode);
        return opcode inside {OP_LDSX, OP_STSX, OP_LDXVX, OP_STXVX, OP_CVLDSX, OP_CVSTSX};
    endfunction

endpackage

// File: rtl/any1_vmem_seq_if.sv
// any1_vmem_seq_if: request/acknowledge bus between the element sequencer and the cache port
interface any1_vmem_seq_if #(parameter int AWID = 32);
    logic            mreq;
    logic            mwe;
    logic [AWID-1:0] madr;
    logic            mack;
    logic            merr;
    modport master(output mreq, mwe, madr, input mack, merr);
    modport slave(input mreq, mwe, madr, output mack, merr);
endinterface

// File: rtl/any1_vmem_seq.sv
// any1_vmem_seq: steps through vector elements, skips masked ones and issues one bus request
// per active element for strided, indexed and compressed vector loads and stores.
module any1_vmem_seq #(
    parameter int NEL  = any1_vmem_seq_pkg::NEL,
    parameter int AWID = 32,
    parameter int VLW  = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   is_store,
    input  logic [VLW-1:0]         vl,
    input  logic [NEL-1:0]         vmask,
    input  logic                   abort,
    output logic [$clog2(NEL)-1:0] step,
    input  logic [AWID-1:0]        ea,
    any1_vmem_seq_if.master        bus,
    output logic [$clog2(NEL)-1:0] elem_idx,
    output logic                   ld_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);
    import any1_vmem_seq_pkg::*;

    vmseq_state_t   state, state_nxt;
    logic           st_store, err_flag, abt_pend, last, stop;
    logic [VLW-1:0] vl_q, vl_clamp;
    logic [NEL-1:0] vmask_q;

    assign vl_clamp = (vl > VLW'(NEL)) ? VLW'(NEL) : vl;
    assign last     = VLW'(step) == vl_q - 1'b1;
    // An abort seen at any point of a request is honoured once its acknowledge arrives
    assign stop     = abort | abt_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = !start ? IDLE : (vl_clamp == '0) ? DONE : STEP;
            STEP:    state_nxt = abort ? IDLE : !vmask_q[step] ? (last ? DONE : STEP) : EAW;
            EAW:     state_nxt = abort ? IDLE : REQ;
            REQ:     state_nxt = !bus.mack ? REQ : stop ? IDLE : (bus.merr || last) ? DONE : STEP;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.mreq = state == REQ;
    assign bus.mwe  = bus.mreq & st_store;
    assign ld_valid = bus.mreq & bus.mack & ~st_store;
    assign busy     = state != IDLE;
    assign done     = (state == DONE) & ~abort;
    assign err      = done & err_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step     <= '0;
            elem_idx <= '0;
            bus.madr <= '0;
            st_store <= 1'b0;
            vl_q     <= '0;
            vmask_q  <= '0;
            err_flag <= 1'b0;
            abt_pend <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                st_store <= is_store;
                vl_q     <= vl_clamp;
                vmask_q  <= vmask;
                step     <= '0;
            end
            if ((state == STEP && !abort && !vmask_q[step] && !last) ||
                (state == REQ && bus.mack && !bus.merr && !stop && !last))
                step <= step + 1'b1;
            if (state == EAW) begin
                bus.madr <= ea;
                elem_idx <= step;
            end
            err_flag <= (state == REQ) ? (bus.mack & bus.merr & ~stop) : (state == DONE) ? 1'b0 : err_flag;
            abt_pend <= (state == REQ) & ~bus.mack & stop;
        end
    end

endmodule
